// File: rtl/exp_histogram_reducer.sv
// exp_histogram_reducer: histogram of signed per-lane ±2^exp terms over a dot product, Horner-reduced to an integer sum on a valid/ready output
module exp_histogram_reducer #(
  parameter int LANES = 16,
  parameter int EXP_W = 4,
  parameter int CNT_W = 12,
  parameter int ACC_W = 28
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES-1:0][EXP_W-1:0]   SumExps,
  input  logic [LANES-1:0]              Signs,
  input  logic [LANES-1:0]              Mask,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [ACC_W-1:0]       out_sum
);
  localparam int NB = 1 << EXP_W;
  typedef enum logic [1:0] {ACCUM, REDUCE, OUTPUT} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] bucket_q [NB];
  logic [CNT_W-1:0] bucket_d [NB];
  logic [CNT_W-1:0] delta [NB];
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [EXP_W-1:0] k_q, k_d;
  assign in_ready  = RSTN && state_q == ACCUM;
  assign out_valid = state_q == OUTPUT;
  assign out_sum   = out_valid ? acc_q : '0;
  always_comb begin
    for (int b = 0; b < NB; b++) delta[b] = '0;
    for (int l = 0; l < LANES; l++)
      if (Mask[l]) delta[SumExps[l]] = Signs[l] ? delta[SumExps[l]] - CNT_W'(1) : delta[SumExps[l]] + CNT_W'(1);
    state_d  = state_q;
    acc_d    = acc_q;
    k_d      = k_q;
    bucket_d = bucket_q;
    if (state_q == ACCUM && in_valid) begin
      for (int b = 0; b < NB; b++) bucket_d[b] = bucket_q[b] + delta[b];
      if (in_last) begin
        state_d = REDUCE;
        acc_d   = '0;
        k_d     = EXP_W'(NB - 1);
      end
    end
    if (state_q == REDUCE) begin
      acc_d   = (acc_q << 1) + ACC_W'($signed(bucket_q[k_q]));
      k_d     = k_q - EXP_W'(1);
      state_d = k_q == '0 ? OUTPUT : REDUCE;
    end
    if (state_q == OUTPUT && out_ready) begin
      state_d = ACCUM;
      for (int b = 0; b < NB; b++) bucket_d[b] = '0;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      k_q     <= '0;
      for (int b = 0; b < NB; b++) bucket_q[b] <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      bucket_q <= bucket_d;
    end
  end
endmodule

// File: tb/tb_exp_histogram_reducer.sv
// tb_exp_histogram_reducer: directed and random jobs checked against an arithmetic histogram model
module tb_exp_histogram_reducer;
  localparam int NB = 16;
  logic CLK = 0;
  logic RSTN = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [15:0][3:0] SumExps = '0;
  logic [15:0] Signs = '0;
  logic [15:0] Mask = '0;
  logic in_last = 0;
  logic out_valid;
  logic out_ready = 0;
  logic signed [27:0] out_sum;
  int total = 0;
  int bad = 0;
  int mh [NB];
  exp_histogram_reducer dut (
    .CLK(CLK), .RSTN(RSTN), .in_valid(in_valid), .in_ready(in_ready),
    .SumExps(SumExps), .Signs(Signs), .Mask(Mask), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
  );
  always #5 CLK = ~CLK;
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
  function automatic logic signed [63:0] model_sum();
    longint s = 0;
    logic signed [27:0] r;
    for (int b = 0; b < NB; b++) begin
      int w = ((mh[b] % 4096) + 4096) % 4096;
      if (w >= 2048) w -= 4096;
      s += longint'(w) * (longint'(1) << b);
    end
    r = s[27:0];
    return r;
  endfunction
  task automatic beat(input logic [63:0] e, input logic [15:0] s, input logic [15:0] m, input logic last);
    int n = 0;
    SumExps = e; Signs = s; Mask = m; in_last = last; in_valid = 1;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) chk("beat_ready_timeout", 0, 1);
    tick();
    in_valid = 0; in_last = 0;
    for (int l = 0; l < 16; l++) if (m[l]) mh[e[4*l +: 4]] += s[l] ? -1 : 1;
  endtask
  task automatic finish_job(input logic signed [63:0] expv, input int hold);
    bit early = 0;
    chk("ready_after_last", in_ready, 0);
    for (int i = 1; i < NB; i++) begin tick(); if (out_valid !== 1'b0) early = 1; end
    chk("no_early_valid", early, 0);
    tick();
    chk("valid_at_latency", out_valid, 1);
    chk("sum", out_sum, expv);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_sum", out_sum, expv);
      chk("hold_valid", out_valid, 1);
    end
    chk("ready_in_output", in_ready, 0);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("valid_drop", out_valid, 0);
    chk("ready_back", in_ready, 1);
    for (int b = 0; b < NB; b++) mh[b] = 0;
  endtask
  initial begin
    bit seen;
    for (int b = 0; b < NB; b++) mh[b] = 0;
    tick(); tick();
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", out_sum, 0);
    RSTN = 1;
    tick();
    chk("idle_ready", in_ready, 1);
    beat({16{4'h3}}, 16'h0000, 16'hFFFF, 1);
    finish_job(128, 0);
    beat({16{4'h5}}, 16'hFF00, 16'hFFFF, 1);
    finish_job(0, 0);
    beat({16{4'h5}}, 16'hFF00, 16'h00FF, 1);
    finish_job(256, 0);
    beat(64'hE, 16'h0000, 16'h0001, 0);
    chk("ready_mid_job", in_ready, 1);
    beat(64'h0, 16'h0002, 16'h0002, 1);
    finish_job(16383, 0);
    for (int i = 0; i < 99; i++) beat({16{4'hE}}, 16'hFFFF, 16'hFFFF, 0);
    beat({16{4'hE}}, 16'hFFFF, 16'hFFFF, 1);
    finish_job(-26214400, 0);
    beat({16{4'h7}}, 16'h00F0, 16'h0FFF, 1);
    finish_job(model_sum(), 5);
    beat(64'h0, 16'h0000, 16'h0001, 1);
    finish_job(1, 0);
    beat({16{4'h9}}, 16'h0000, 16'hFFFF, 1);
    for (int i = 0; i < 5; i++) tick();
    RSTN = 0;
    tick();
    chk("reset_ready_low", in_ready, 0);
    chk("reset_valid_low", out_valid, 0);
    RSTN = 1;
    for (int b = 0; b < NB; b++) mh[b] = 0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin tick(); if (out_valid !== 1'b0) seen = 1; end
    chk("aborted_no_output", seen, 0);
    beat(64'h200, 16'h0004, 16'h0004, 1);
    finish_job(-4, 0);
    beat(64'h0, 16'h0000, 16'h0000, 1);
    finish_job(0, 0);
    for (int j = 0; j < 8; j++) begin
      int nb = $urandom_range(1, 4);
      for (int i = 0; i < nb; i++)
        beat({$urandom, $urandom}, 16'($urandom), 16'($urandom), i == nb - 1);
      finish_job(model_sum(), $urandom_range(0, 2));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exp_histogram_reducer.md
Name: exp_histogram_reducer

Overview:
- Downstream neighbour of the PE exponent/sign stage. Consumes per-lane product exponents (sum of A and B exponents) and product signs, 16 lanes per beat.
- Builds a signed histogram with one count per exponent bucket, accumulated over a multi-beat dot product terminated by in_last.
- Reduces the histogram to the integer sum of ±2^exp using a sequential Horner shift-add, then presents the result on a valid/ready output.

Parameters:
- LANES, 16, lanes per input beat.
- EXP_W, 4, product-exponent width; bucket count NB = 2^EXP_W = 16.
- CNT_W, 12, signed two's-complement width of each bucket count.
- ACC_W, 28, signed result width; must be at least CNT_W+NB.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RSTN  input  1  synchronous active-low reset.
- in_valid  input  1  beat valid.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- SumExps  input  [LANES-1:0][EXP_W-1:0]  per-lane product exponent.
- Signs  input  [LANES-1:0]  per-lane product sign, 1 = negative.
- Mask  input  [LANES-1:0]  lane enable, 0 = lane contributes nothing (bit-sparse skip).
- in_last  input  1  marks the final beat of a dot product.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_W  signed result.

Behaviour:
- Reset (RSTN low at an edge):
  - state goes to ACCUM.
  - All buckets, the accumulator, and the step index are cleared to 0.
  - out_valid = 0 and out_sum = 0.
  - in_ready = 0 while RSTN is low.
  - Reset in any state, including mid-REDUCE or OUTPUT, abandons the pending result; no partial output is ever emitted.
- States: ACCUM, REDUCE, OUTPUT.
- ACCUM:
  - in_ready = 1.
  - On an accepted beat, each bucket b is updated once: bucket[b] += (number of lanes with Mask=1, SumExps=b, Signs=0) − (number of lanes with Mask=1, SumExps=b, Signs=1).
  - The per-beat delta per bucket lies in −LANES..+LANES. Buckets wrap modulo 2^CNT_W with no saturation; overflow is the caller's responsibility.
  - An accepted beat with in_last=1 includes that beat's contribution, then moves to REDUCE with acc=0 and k=NB−1.
  - in_valid=1 with in_last=0 stays in ACCUM.
  - Upstream must hold inputs stable while in_valid && !in_ready.
- REDUCE:
  - in_ready = 0.
  - Each cycle: acc ← (acc<<1) + sign-extended bucket[k]; then k ← k−1.
  - After the k=0 step, the block moves to OUTPUT. This takes exactly NB cycles.
  - Latency: if the in_last beat is accepted at edge E0, out_valid rises at edge E0+NB (E0+16 at defaults).
- OUTPUT:
  - out_valid = 1, out_sum = acc, both held stable until out_ready=1.
  - On the handshake edge: out_valid → 0, all buckets → 0, state → ACCUM.
  - in_ready rises in the following cycle; there is no same-cycle bypass.
- Empty dot product: an in_last beat with Mask all zero, and no prior beats, yields out_sum = 0 and still takes the full NB-cycle latency.
- in_valid is ignored outside ACCUM. out_ready is ignored outside OUTPUT.

Test Plan:
- Single beat with in_last: all 16 lanes SumExps=3, Signs=0, Mask=all ones → out_valid 16 cycles after acceptance, out_sum = 128.
- Single beat with in_last: lanes 0–7 exp 5 positive, lanes 8–15 exp 5 negative → out_sum = 0. Repeat with Mask=0x00FF → out_sum = 256.
- Two beats: beat1 has only lane0 active, exp 14 positive; beat2 (in_last) has only lane1 active, exp 0 negative → out_sum = 16383. in_ready must be low from the cycle after the last acceptance until the cycle after the output handshake.
- 100 beats, last one with in_last, all lanes exp 14 negative, Mask all ones → out_sum = −26214400.
- Output backpressure: hold out_ready=0 for 5 cycles while out_valid=1 → out_sum stable and in_ready=0. After the handshake, the next single-beat job (lane0 exp 0 positive) → out_sum = 1, showing the buckets were cleared.
- Reset: assert RSTN=0 for 1 cycle mid-REDUCE → out_valid stays 0, no output appears for the aborted job. The next job (lane2 exp 2 negative) → out_sum = −4.
